// File: rtl/s298_state_bank.sv
// s298 state-register bank: eight state flops captured from the next-state cones under a step-count run controller.
// Optional scan chain through the state flops when S298_SCAN_EN is defined.
module s298_state_bank #(
    parameter int unsigned CW      = 8,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          INIT_LOAD,
    input  logic [7:0]    INIT_VAL,
    input  logic          START,
    input  logic [CW-1:0] NSTEPS,
    input  logic [7:0]    NS_IN,
`ifdef S298_SCAN_EN
    input  logic          SCAN_MODE,
    input  logic          SCAN_IN,
    output logic          SCAN_OUT,
`endif
    output logic          G10,
    output logic          G11,
    output logic          G12,
    output logic          G13,
    output logic          G14,
    output logic          G15,
    output logic          G19,
    output logic          G22,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] STEP_CNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [7:0]    st_q, st_d;      // {G22,G19,G15,G14,G13,G12,G11,G10}
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          scan_shift;

`ifdef S298_SCAN_EN
    assign scan_shift = SCAN_MODE;
    assign SCAN_OUT   = st_q[7];
`else
    assign scan_shift = 1'b0;
`endif

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        if (scan_shift) begin
`ifdef S298_SCAN_EN
            st_d = {st_q[6:0], SCAN_IN};
`endif
        end else begin
            unique case (fsm_q)
                S_IDLE, S_DONE: begin
                    if (INIT_LOAD) begin
                        st_d  = INIT_VAL;
                        fsm_d = S_IDLE;
                    end else if (START) begin
                        cnt_d = '0;
                        if (NSTEPS != '0) begin
                            rem_d = NSTEPS;
                            fsm_d = S_RUN;
                        end else begin
                            fsm_d = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    st_d  = NS_IN;
                    rem_d = rem_q - CW'(1);
                    if (cnt_q != '1)
                        cnt_d = cnt_q + CW'(1);
                    if (rem_q == CW'(1))
                        fsm_d = S_DONE;
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            fsm_q <= S_IDLE;
            st_q  <= RST_VAL;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign {G22, G19, G15, G14, G13, G12, G11, G10} = st_q;
    assign BUSY     = (fsm_q == S_RUN);
    assign DONE     = (fsm_q == S_DONE);
    assign STEP_CNT = cnt_q;

endmodule

// File: tb/tb_s298_state_bank.sv
// Scoreboard bench for s298_state_bank: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
// Scan-chain vectors are included when S298_SCAN_EN is defined.
module tb_s298_state_bank;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       INIT_LOAD = 1'b0;
    logic [7:0] INIT_VAL = 8'h00;
    logic       START = 1'b0;
    logic [7:0] NSTEPS = 8'h00;
    logic [7:0] NS_IN = 8'h00;
    logic       G10, G11, G12, G13, G14, G15, G19, G22;
    logic       BUSY, DONE;
    logic [7:0] STEP_CNT;
`ifdef S298_SCAN_EN
    logic       SCAN_MODE = 1'b0;
    logic       SCAN_IN = 1'b0;
    logic       SCAN_OUT;
`endif

    s298_state_bank #(.CW(8), .RST_VAL(8'h00)) dut (
        .CK(CK), .RST(RST), .INIT_LOAD(INIT_LOAD), .INIT_VAL(INIT_VAL),
        .START(START), .NSTEPS(NSTEPS), .NS_IN(NS_IN),
`ifdef S298_SCAN_EN
        .SCAN_MODE(SCAN_MODE), .SCAN_IN(SCAN_IN), .SCAN_OUT(SCAN_OUT),
`endif
        .G10(G10), .G11(G11), .G12(G12), .G13(G13), .G14(G14), .G15(G15),
        .G19(G19), .G22(G22), .BUSY(BUSY), .DONE(DONE), .STEP_CNT(STEP_CNT)
    );

    always #5 CK = ~CK;

    typedef struct {
        string      name;
        logic [7:0] st;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
        logic       so;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: outputs are registered, so mid-cycle sampling sees the result of the preceding edge.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge CK);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {G22, G19, G15, G14, G13, G12, G11, G10};
                tests++;
                if (act !== e.st || BUSY !== e.busy || DONE !== e.done || STEP_CNT !== e.cnt) begin
                    fails++;
                    $display("FAIL %s: got st=%h busy=%b done=%b cnt=%0d, expected st=%h busy=%b done=%b cnt=%0d",
                             e.name, act, BUSY, DONE, STEP_CNT, e.st, e.busy, e.done, e.cnt);
                end
`ifdef S298_SCAN_EN
                if (e.name == "scan_shift8") begin
                    tests++;
                    if (SCAN_OUT !== e.so) begin
                        fails++;
                        $display("FAIL scan_out: got %b, expected %b", SCAN_OUT, e.so);
                    end
                end
`endif
            end
        end
    end

    task automatic step(input string nm, input logic [7:0] st, input logic b, input logic d,
                        input logic [7:0] c, input logic so = 1'b0);
        exp_t e;
        @(posedge CK);
        #1;
        e.name = nm; e.st = st; e.busy = b; e.done = d; e.cnt = c; e.so = so;
        q.push_back(e);
    endtask

    task automatic idle_in();
        RST = 1'b0; INIT_LOAD = 1'b0; START = 1'b0;
    endtask

    initial begin
        // Reset
        RST = 1'b1; NS_IN = 8'hFF;
        step("reset", 8'h00, 0, 0, 8'd0);
        // Preset
        idle_in(); INIT_LOAD = 1'b1; INIT_VAL = 8'h5A;
        step("init_load", 8'h5A, 0, 0, 8'd0);
        idle_in(); NS_IN = 8'hFF;
        step("idle_hold", 8'h5A, 0, 0, 8'd0);
        // Three-step run
        START = 1'b1; NSTEPS = 8'd3;
        step("start3", 8'h5A, 1, 0, 8'd0);
        idle_in(); NS_IN = 8'h01;
        step("run_step1", 8'h01, 1, 0, 8'd1);
        NS_IN = 8'h02;
        step("run_step2", 8'h02, 1, 0, 8'd2);
        NS_IN = 8'h04;
        step("run_step3", 8'h04, 0, 1, 8'd3);
        NS_IN = 8'hFF;
        step("done_hold", 8'h04, 0, 1, 8'd3);
        // INIT_LOAD beats START in DONE; STEP_CNT kept
        INIT_LOAD = 1'b1; START = 1'b1; INIT_VAL = 8'h3C; NSTEPS = 8'd5;
        step("init_beats_start", 8'h3C, 0, 0, 8'd3);
        // Zero-length run
        idle_in(); START = 1'b1; NSTEPS = 8'd0;
        step("start0", 8'h3C, 0, 1, 8'd0);
        // Ten-step run aborted by reset
        START = 1'b1; NSTEPS = 8'd10; NS_IN = 8'h11;
        step("start10", 8'h3C, 1, 0, 8'd0);
        idle_in(); NS_IN = 8'h21;
        step("run10_s1", 8'h21, 1, 0, 8'd1);
        NS_IN = 8'h22;
        step("run10_s2", 8'h22, 1, 0, 8'd2);
        INIT_LOAD = 1'b1; START = 1'b1; INIT_VAL = 8'h99; NSTEPS = 8'd0; NS_IN = 8'h23;
        step("run_ignores_ctl", 8'h23, 1, 0, 8'd3);
        idle_in(); NS_IN = 8'h24;
        step("run10_s4", 8'h24, 1, 0, 8'd4);
        RST = 1'b1; INIT_LOAD = 1'b1; INIT_VAL = 8'hAA; NS_IN = 8'hFF;
        step("rst_mid_run", 8'h00, 0, 0, 8'd0);
        idle_in();
        step("post_rst_idle", 8'h00, 0, 0, 8'd0);
        // Single-step run
        START = 1'b1; NSTEPS = 8'd1;
        step("start1", 8'h00, 1, 0, 8'd0);
        idle_in(); NS_IN = 8'h77;
        step("run1_done", 8'h77, 0, 1, 8'd1);
`ifdef S298_SCAN_EN
        // Shift 1,0,1,1,0,0,1,0; first bit ends in G22 -> 8'hB2; FSM and STEP_CNT frozen
        begin
            logic [7:0] bits;
            bits = 8'b1011_0010;
            SCAN_MODE = 1'b1; START = 1'b1; NSTEPS = 8'd4; INIT_LOAD = 1'b1;
            for (int i = 7; i >= 1; i--) begin
                SCAN_IN = bits[i];
                @(posedge CK);
                #1;
            end
            SCAN_IN = bits[0];
            step("scan_shift8", 8'hB2, 0, 1, 8'd1, 1'b1);
            SCAN_MODE = 1'b0; INIT_LOAD = 1'b0; START = 1'b1; NSTEPS = 8'd0;
            step("scan_exit_start0", 8'hB2, 0, 1, 8'd0);
            idle_in();
        end
`endif
        // Drain scoreboard with a bounded wait
        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 20) begin
                @(posedge CK);
                budget++;
            end
            if (q.size() > 0) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            end
        end
        @(posedge CK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
